bcd_mod_counter: RTL
====================

# bcd_mod_counter

Parametrised two-digit BCD modulo counter: the generalised successor of the fixed 24-hour hour counter. One module covers the hours (MODULO=24 or 12), minutes and seconds (MODULO=60) stages of the clock chain.
- Up/down counting with cascade carry.
- Time-set mode with per-digit adjustment; tens adjustment clamps the ones digit so the value stays legal.
- Parallel preset with a range check.
- All state is synchronous to `CLK`.

## Interface
- `MODULO`, default 24: count range 0..MODULO-1. Legal 2..100.
- `TENS_W`, default 2: width of the tens digit. Must hold (MODULO-1)/10, and is at most 4.

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `RESET`, in, 1: reset is synchronous and active-high.
- `ENABLE`, in, 1: global count enable (timebase tick).
- `CIN`, in, 1: carry-in from the previous stage.
- `SEL_DOWN`, in, 1: 0 = count up, 1 = count down. Applies to counting and to set adjustments.
- `BASE`, in, 1: 1 = normal run mode, 0 = time-set mode.
- `SET_PULSE`, in, 1: one-cycle adjust strobe (debounced button).
- `SET_ONES`, in, 1: adjust-target select for the ones digit.
- `SET_TENS`, in, 1: adjust-target select for the tens digit.
- `LOAD`, in, 1: parallel preset strobe.
- `LOAD_ONES`, in, 4: preset value for the ones digit.
- `LOAD_TENS`, in, TENS_W: preset value for the tens digit.
- `ONES`, out, 4: ones digit, BCD.
- `TENS`, out, TENS_W: tens digit.
- `COUT`, out, 1: carry/borrow out (combinational).
- `LOAD_ERR`, out, 1: sticky flag, set when a preset was rejected.

## Operation
Definitions:
- V = 10*TENS + ONES.
- MAXT = (MODULO-1)/10.
- MAXO(t) = (MODULO-1)%10 when t==MAXT, otherwise 9.

Priority per clock edge: `RESET` > `LOAD` > set adjust > count.
- **RESET**: `ONES`=0, `TENS`=0, `LOAD_ERR`=0.
- **LOAD**:
  - If LOAD_ONES ≤ 9 and 10*LOAD_TENS + LOAD_ONES ≤ MODULO-1: both digits take the preset values and `LOAD_ERR` clears.
  - Otherwise the digits are unchanged and `LOAD_ERR` sets. It stays set until `RESET` or the next valid `LOAD`.
  - `LOAD` is honoured in either mode.
- **Set adjust** fires when `BASE`=0 and `SET_PULSE`=1.
  - If `SET_TENS`=1, only tens is adjusted, even when `SET_ONES`=1 as well.
    - Up: TENS wraps from MAXT to 0. Down: TENS wraps from 0 to MAXT.
    - If the current ONES > MAXO(new TENS), ONES is clamped to MAXO(new TENS) in the same cycle.
  - Else if `SET_ONES`=1, only ones is adjusted.
    - Up: ONES wraps from MAXO(TENS) to 0. Down: ONES wraps from 0 to MAXO(TENS).
    - TENS is never touched.
  - If neither select is set, there is no change.
- **Count** fires when `BASE`=1, `ENABLE`=1 and `CIN`=1.
  - Up: V==MODULO-1 goes to 0. Otherwise, ONES==9 goes to ONES=0 with TENS+1; else ONES+1.
  - Down: V==0 goes to MODULO-1 (ONES=MAXO(MAXT), TENS=MAXT). Otherwise, ONES==0 goes to ONES=9 with TENS-1; else ONES-1.
- **Hold**: in every other case the digits hold.
- **COUT** = `BASE` & `ENABLE` & `CIN` & (up ? V==MODULO-1 : V==0).
  - It is 0 in set mode, so set actions never ripple into the next stage.
- **MODULO ≤ 10**: TENS stays 0; `SET_TENS` pulses leave TENS at 0 and only apply the clamp.
- Out-of-range V is unreachable by design: reset, load check, clamp and wrap rules keep V < MODULO at all times.

## Timing
- Every register updates on the rising edge of `CLK`. New values of `ONES`, `TENS` and `LOAD_ERR` are visible 1 cycle after the qualifying inputs.
- `COUT` is combinational from the current state and inputs, with 0-cycle latency. This allows a same-edge cascade: the next stage uses `COUT` as its `CIN`.
- `RESET` is sampled only at a clock edge. If it is asserted mid-count or mid-set, the next edge gives the reset values and all other inputs are ignored that cycle.
  - While `RESET`=1: `COUT` is still derived from the held state (0 after the first edge, since V==0 in up mode). In down mode V==0 makes `COUT`=1 if `CIN` and `ENABLE` are high; the downstream stage is in reset too.
- `SET_PULSE` must be a single-cycle strobe. Holding it for N cycles produces N adjustments.
- Switching `BASE` or `SEL_DOWN` takes effect on the next edge. No state is kept across mode changes other than the digits.

## Test plan
- **Up count, MODULO=24**: reset, then hold `ENABLE`=`CIN`=1 with up selected.
  - 9 → 10 and 19 → 20.
  - At 23, `COUT`=1 in the same cycle; the next edge gives 00 with `COUT`=0.
- **Down count, MODULO=60**: start from 00 with `CIN`=1 → `COUT`=1, next value 59. Then 50 → 49.
- **Time-set clamp, MODULO=24**:
  - `LOAD` 19, then `BASE`=0, `SET_TENS`+`SET_PULSE` up → 23. One more tens pulse → 03.
  - At 23, a `SET_ONES` up pulse → 20. A `SET_ONES` down pulse from 20 → 23.
- **Load check**:
  - `LOAD` 25 with MODULO=24 → digits unchanged, `LOAD_ERR`=1.
  - `LOAD` tens=1, ones=10 → rejected.
  - `LOAD` 12 → digits 12, `LOAD_ERR`=0.
- **Set mode isolation**: `BASE`=0 with `ENABLE`=`CIN`=1 at 23 → no count, `COUT`=0. `SET_PULSE` with no select → no change.
- **Reset mid-operation and MODULO=12**:
  - `RESET` together with `LOAD` 11 → 00.
  - With MODULO=12 in down mode, 00 → 11, and 10 → 09.

Source files
------------

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter stage for a clock chain (hours, minutes, seconds).
// It counts up or down with a cascade carry, supports time-set adjustment of each
// digit with a legality clamp, and accepts a range-checked parallel preset.
module bcd_mod_counter #(
    parameter int MODULO = 24,
    parameter int TENS_W = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              CIN,
    input  logic              SEL_DOWN,
    input  logic              BASE,
    input  logic              SET_PULSE,
    input  logic              SET_ONES,
    input  logic              SET_TENS,
    input  logic              LOAD,
    input  logic [3:0]        LOAD_ONES,
    input  logic [TENS_W-1:0] LOAD_TENS,
    output logic [3:0]        ONES,
    output logic [TENS_W-1:0] TENS,
    output logic              COUT,
    output logic              LOAD_ERR
);

    // Highest tens digit, and the highest ones digit when tens is at that top value.
    localparam int                MAXT_I   = (MODULO - 1) / 10;
    localparam logic [TENS_W-1:0] MAXT     = TENS_W'(MAXT_I);
    localparam logic [3:0]        MAXO_TOP = 4'((MODULO - 1) % 10);
    localparam logic [7:0]        VMAX     = 8'(MODULO - 1);

    logic [3:0]        ones_q, ones_d;
    logic [TENS_W-1:0] tens_q, tens_d;
    logic              err_q, err_d;
    logic [TENS_W-1:0] adj_tens;
    logic [7:0]        cur_v;
    logic [7:0]        load_v;
    logic              load_ok;
    logic              set_fire;
    logic              count_fire;
    logic              at_end;

    // Largest legal ones digit for a given tens digit.
    function automatic logic [3:0] maxo(input logic [TENS_W-1:0] t);
        return (t == MAXT) ? MAXO_TOP : 4'd9;
    endfunction

    // Decode the current value, the preset check and the action qualifiers.
    always_comb begin
        cur_v      = 8'(tens_q) * 8'd10 + 8'(ones_q);
        load_v     = 8'(LOAD_TENS) * 8'd10 + 8'(LOAD_ONES);
        load_ok    = (LOAD_ONES <= 4'd9) && (load_v <= VMAX);
        set_fire   = !BASE && SET_PULSE;
        count_fire = BASE && ENABLE && CIN;
        // Terminal value in the current direction: last value up, zero down.
        at_end     = SEL_DOWN ? (cur_v == 8'd0) : (cur_v == VMAX);
        COUT       = count_fire && at_end;
        // Tens value after a tens adjustment, wrapping inside 0..MAXT.
        if (SEL_DOWN) begin
            adj_tens = (tens_q == '0) ? MAXT : tens_q - TENS_W'(1);
        end else begin
            adj_tens = (tens_q == MAXT) ? '0 : tens_q + TENS_W'(1);
        end
    end

    // Next-state selection: load, then set adjust, then count, else hold.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        err_d  = err_q;
        if (LOAD) begin
            if (load_ok) begin
                ones_d = LOAD_ONES;
                tens_d = LOAD_TENS;
                err_d  = 1'b0;
            end else begin
                err_d  = 1'b1;
            end
        end else if (set_fire) begin
            if (SET_TENS) begin
                tens_d = adj_tens;
                // Pull the ones digit down so the new value stays below MODULO.
                if (ones_q > maxo(adj_tens)) begin
                    ones_d = maxo(adj_tens);
                end
            end else if (SET_ONES) begin
                if (SEL_DOWN) begin
                    ones_d = (ones_q == 4'd0) ? maxo(tens_q) : ones_q - 4'd1;
                end else begin
                    ones_d = (ones_q == maxo(tens_q)) ? 4'd0 : ones_q + 4'd1;
                end
            end
        end else if (count_fire) begin
            if (SEL_DOWN) begin
                if (at_end) begin
                    ones_d = MAXO_TOP;
                    tens_d = MAXT;
                end else if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - TENS_W'(1);
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end else begin
                if (at_end) begin
                    ones_d = 4'd0;
                    tens_d = '0;
                end else if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + TENS_W'(1);
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end
        end
    end

    // Digit and error-flag registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ones_q <= 4'd0;
            tens_q <= '0;
            err_q  <= 1'b0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
            err_q  <= err_d;
        end
    end

    assign ONES     = ones_q;
    assign TENS     = tens_q;
    assign LOAD_ERR = err_q;

endmodule
